// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: bus-mapped multiplexed 7-segment display controller.
// It holds three registers: DATA (one hex nibble per digit), CTRL (enable, blank
// mask, decimal-point mask) and BRIGHT (PWM duty level). It scans DIGITS
// common-anode digits in turn and dims each digit slot by PWM.
// All pin outputs are registered. They are computed from the scan counters and
// register values that hold during the previous cycle.
// Legal parameters: DIGITS in 1..8; SCAN_DIV a multiple of 16 and at least 16.
module seg_scan_ctrl #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              wen,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [DIGITS-1:0] dig_en,
  output logic [6:0]        seg,
  output logic              seg_dp
);

  // One digit slot has 16 PWM phases. Each phase lasts SCAN_DIV/16 cycles.
  localparam int PRE_MAX = SCAN_DIV / 16;
  localparam int PRE_W   = (PRE_MAX > 1) ? $clog2(PRE_MAX) : 1;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_MAX - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_CTRL   = 2'd1,
    REG_BRIGHT = 2'd2,
    REG_RSVD   = 2'd3
  } reg_sel_e;

  reg_sel_e sel;
  assign sel = reg_sel_e'(addr[3:2]);

  // Only addr[3:2] and the low register fields are decoded. The rest of the bus is ignored.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{addr[31:4], addr[1:0], wdata};

  // Active-low hex font, bit order G..A.
  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] f;
    unique case (v)
      4'h0: f = 7'b1000000;
      4'h1: f = 7'b1111001;
      4'h2: f = 7'b0100100;
      4'h3: f = 7'b0110000;
      4'h4: f = 7'b0011001;
      4'h5: f = 7'b0010010;
      4'h6: f = 7'b0000010;
      4'h7: f = 7'b1111000;
      4'h8: f = 7'b0000000;
      4'h9: f = 7'b0010000;
      4'hA: f = 7'b0001000;
      4'hB: f = 7'b0000011;
      4'hC: f = 7'b1000110;
      4'hD: f = 7'b0100001;
      4'hE: f = 7'b0000110;
      default: f = 7'b0001110;
    endcase
    return f;
  endfunction

  // Register file.
  logic [4*DIGITS-1:0] data_q, data_d;
  logic                en_q, en_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [3:0]          bright_q, bright_d;

  // Scan counters.
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [3:0]          phase_q, phase_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  // Registered pin drivers.
  logic [DIGITS-1:0]   dig_en_q, dig_en_d;
  logic [6:0]          seg_q, seg_d;
  logic                seg_dp_q, seg_dp_d;

  logic                lit;
  logic [3:0]          nibble;

  // Bus write decode. Bits above the configured digit count are dropped.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can leave a latch.
    data_d   = data_q;
    en_d     = en_q;
    blank_d  = blank_q;
    dp_d     = dp_q;
    bright_d = bright_q;
    if (wen) begin
      unique case (sel)
        REG_DATA:   data_d = wdata[4*DIGITS-1:0];
        REG_CTRL: begin
          en_d    = wdata[0];
          blank_d = wdata[8 +: DIGITS];
          dp_d    = wdata[16 +: DIGITS];
        end
        REG_BRIGHT: bright_d = wdata[3:0];
        default: ;
      endcase
    end
  end

  // Combinational read-back. Unimplemented bits read as zero.
  always_comb begin
    rdata = '0;
    unique case (sel)
      REG_DATA:   rdata[4*DIGITS-1:0] = data_q;
      REG_CTRL: begin
        rdata[0]           = en_q;
        rdata[8 +: DIGITS]  = blank_q;
        rdata[16 +: DIGITS] = dp_q;
      end
      REG_BRIGHT: rdata[3:0] = bright_q;
      default: ;
    endcase
  end

  // Scan sequencing: prescaler, then phase, then digit index.
  // All three are held at 0 while the display is disabled.
  always_comb begin
    pre_d   = pre_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    if (!en_q) begin
      pre_d   = '0;
      phase_d = '0;
      idx_d   = '0;
    end else if (pre_q == PRE_LAST) begin
      pre_d   = '0;
      phase_d = phase_q + 4'd1;
      if (phase_q == 4'hF) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  // Pin values for the next edge, from the current scan position and register values.
  always_comb begin
    nibble   = data_q[{idx_q, 2'b00} +: 4];
    lit      = en_q && (phase_q <= bright_q) && !blank_q[idx_q];
    dig_en_d = '1;
    seg_d    = 7'h7F;
    seg_dp_d = 1'b1;
    if (lit) begin
      dig_en_d[idx_q] = 1'b0;
      seg_d           = hex_font(nibble);
      seg_dp_d        = ~dp_q[idx_q];
    end
  end

  // Register state. Reset gives EN=1 and full brightness.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
      data_q   <= '0;
      en_q     <= 1'b1;
      blank_q  <= '0;
      dp_q     <= '0;
      bright_q <= 4'hF;
    end else begin
      data_q   <= data_d;
      en_q     <= en_d;
      blank_q  <= blank_d;
      dp_q     <= dp_d;
      bright_q <= bright_d;
    end
  end

  // Scan counter state. Reset aborts any partial slot.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      pre_q   <= '0;
      phase_q <= '0;
      idx_q   <= '0;
    end else begin
      pre_q   <= pre_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

  // Output flops. They go dark as soon as reset is asserted.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      dig_en_q <= '1;
      seg_q    <= 7'h7F;
      seg_dp_q <= 1'b1;
    end else begin
      dig_en_q <= dig_en_d;
      seg_q    <= seg_d;
      seg_dp_q <= seg_dp_d;
    end
  end

  assign dig_en = dig_en_q;
  assign seg    = seg_q;
  assign seg_dp = seg_dp_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl. The main instance has 8 digits and a 32-cycle slot.
// A second 4-digit instance covers register width limits.
// The reference model tracks how many cycles the scan has run. It derives the
// digit and phase from that count by division.
module tb_seg_scan_ctrl;

  localparam int DIG = 8;
  localparam int SD  = 32;
  localparam logic [31:0] CTRL_MASK = 32'h00FF_FF01;

  logic           cpu_clk = 1'b0;
  logic           cpu_rst;
  logic           wen;
  logic [31:0]    addr, wdata, rdata;
  logic [DIG-1:0] dig_en;
  logic [6:0]     seg;
  logic           seg_dp;

  logic           wen2;
  logic [31:0]    addr2, wdata2, rdata2;
  logic [3:0]     dig_en2;
  logic [6:0]     seg2;
  logic           seg_dp2;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state.
  logic [31:0] m_data;
  logic [31:0] m_ctrl;
  logic [3:0]  m_bright;
  int          t;

  logic [6:0] font [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  always #5 cpu_clk = ~cpu_clk;

  seg_scan_ctrl #(.DIGITS(DIG), .SCAN_DIV(SD)) dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .wen     (wen),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .dig_en  (dig_en),
    .seg     (seg),
    .seg_dp  (seg_dp)
  );

  seg_scan_ctrl #(.DIGITS(4), .SCAN_DIV(16)) dut4 (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .wen     (wen2),
    .addr    (addr2),
    .wdata   (wdata2),
    .rdata   (rdata2),
    .dig_en  (dig_en2),
    .seg     (seg2),
    .seg_dp  (seg_dp2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic m_reset();
    m_data   = 32'h0;
    m_ctrl   = 32'h1;
    m_bright = 4'hF;
    t        = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a[3:2])
      2'd0:    return m_data;
      2'd1:    return m_ctrl;
      2'd2:    return {28'h0, m_bright};
      default: return 32'h0;
    endcase
  endfunction

  // One clock cycle. Drive the bus, predict the pins after the edge, then compare at the negedge.
  task automatic cycle(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic [DIG-1:0] e_dig;
    logic [6:0]     e_seg;
    logic           e_dp;
    logic [3:0]     nib;
    int             idx, ph;
    logic           lit;
    wen   = w;
    addr  = a;
    wdata = d;
    idx   = (t / SD) % DIG;
    ph    = (t % SD) / (SD / 16);
    lit   = m_ctrl[0] && (ph <= int'(m_bright)) && !m_ctrl[8 + idx];
    nib   = 4'(m_data >> (4 * idx));
    e_dig = '1;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (lit) begin
      e_dig[idx] = 1'b0;
      e_seg      = font[nib];
      e_dp       = ~m_ctrl[16 + idx];
    end
    t = m_ctrl[0] ? t + 1 : 0;
    if (w) begin
      case (a[3:2])
        2'd0: m_data   = d;
        2'd1: m_ctrl   = d & CTRL_MASK;
        2'd2: m_bright = d[3:0];
        default: ;
      endcase
    end
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    wen = 1'b0;
    check("dig_en", 32'(dig_en), 32'(e_dig));
    check("seg",    32'(seg),    32'(e_seg));
    check("seg_dp", 32'(seg_dp), 32'(e_dp));
    check("rdata",  rdata,       m_read(a));
  endtask

  task automatic run(input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = $urandom;
      cycle(1'b0, a, $urandom);
    end
  endtask

  // Watchdog. A hung run still reports a failure.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        reached;
    logic [31:0] r, a, d;
    int          guard;
    int          sel;

    cpu_rst = 1'b1;
    wen = 1'b0; addr = 32'h0; wdata = 32'h0;
    wen2 = 1'b0; addr2 = 32'h0; wdata2 = 32'h0;
    #1;
    check("rst_dig_en", 32'(dig_en), 32'hFF);
    check("rst_seg",    32'(seg),    32'h7F);
    check("rst_seg_dp", 32'(seg_dp), 32'h1);
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    m_reset();

    // Scan order and font.
    cycle(1'b1, 32'h0, 32'h7654_3210);
    run(300);

    // Blank and decimal-point masks.
    cycle(1'b1, 32'h4, 32'h0081_0201);
    run(260);
    cycle(1'b0, 32'h4, 32'h0);

    // PWM duty at two levels.
    cycle(1'b1, 32'h4, 32'h1);
    cycle(1'b1, 32'h8, 32'h3);
    run(260);
    cycle(1'b1, 32'h8, 32'h0);
    run(260);
    cycle(1'b1, 32'h8, 32'hF);

    // Disable mid-slot on digit 5, then re-enable.
    reached = 1'b0;
    guard   = 0;
    while (!reached && guard < 2000) begin
      if (((t / SD) % DIG) == 5 && (t % SD) == 10) reached = 1'b1;
      else cycle(1'b0, 32'h0, 32'h0);
      guard++;
    end
    check("reach_digit5", 32'(reached), 32'h1);
    cycle(1'b1, 32'h4, 32'h0);
    run(20);
    cycle(1'b1, 32'h4, 32'h1);
    run(SD + 8);

    // Width limits on the 4-digit instance.
    wen2 = 1'b1; addr2 = 32'h0; wdata2 = 32'hFFFF_FFFF;
    cycle(1'b0, 32'h0, 32'h0);
    addr2 = 32'h4;
    cycle(1'b0, 32'h0, 32'h0);
    addr2 = 32'hC; wdata2 = 32'h1234_5678;
    cycle(1'b0, 32'h0, 32'h0);
    wen2 = 1'b0;
    addr2 = 32'h0; #1;
    check("w4_data", rdata2, 32'h0000_FFFF);
    addr2 = 32'h4; #1;
    check("w4_ctrl", rdata2, 32'h000F_0F01);
    addr2 = 32'h8; #1;
    check("w4_bright", rdata2, 32'h0000_000F);
    addr2 = 32'hC; #1;
    check("w4_rsvd", rdata2, 32'h0);
    check("w4_dig_en", 32'(dig_en2), 32'hF);

    // Reset asserted mid-scan.
    run(45);
    cpu_rst = 1'b1;
    #1;
    check("mid_rst_dig_en", 32'(dig_en), 32'hFF);
    check("mid_rst_seg",    32'(seg),    32'h7F);
    check("mid_rst_seg_dp", 32'(seg_dp), 32'h1);
    addr = 32'h4; #1;
    check("mid_rst_ctrl", rdata, 32'h1);
    addr = 32'h8; #1;
    check("mid_rst_bright", rdata, 32'hF);
    addr = 32'h0; #1;
    check("mid_rst_data", rdata, 32'h0);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    m_reset();
    run(40);

    // Random register traffic compared against the model.
    for (int i = 0; i < 2000; i++) begin
      r   = $urandom;
      sel = $urandom_range(0, 3);
      a   = {r[31:4], 2'(sel), r[1:0]};
      d   = $urandom;
      if (sel == 1) d[0] = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) cycle(1'b1, a, d);
      else cycle(1'b0, a, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
